// File: rtl/lcd_timing_pkg.sv
// Shared timing defaults, frame-total helper and RGB565 colour-bar constants
// for the 480x272 LCD timing generator.
package lcd_timing_pkg;

    localparam int DEF_H_ACTIVE = 480;
    localparam int DEF_H_FP     = 2;
    localparam int DEF_H_SYNC   = 41;
    localparam int DEF_H_BP     = 2;
    localparam int DEF_V_ACTIVE = 272;
    localparam int DEF_V_FP     = 2;
    localparam int DEF_V_SYNC   = 10;
    localparam int DEF_V_BP     = 2;
    localparam int DEF_CNT_W    = 10;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    function automatic int line_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return RGB_WHITE;
            3'd1:    return RGB_YELLOW;
            3'd2:    return RGB_CYAN;
            3'd3:    return RGB_GREEN;
            3'd4:    return RGB_MAGENTA;
            3'd5:    return RGB_RED;
            3'd6:    return RGB_BLUE;
            default: return RGB_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/lcd_colour_bars.sv
// Eight vertical RGB565 colour bars; bar index tracked with a bar-width
// down-counter reloaded at each line start, so no divider is needed.
module lcd_colour_bars
    import lcd_timing_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int BAR_W = DEF_H_ACTIVE / 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        line_load,
    input  logic        de_next,
    output logic [15:0] rgb
);

    localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);

    logic [CNT_W-1:0] bar_cnt;
    logic [CNT_W-1:0] bar_cnt_next;
    logic [2:0]       bar_idx;
    logic [2:0]       bar_idx_next;

    // Decoded from the next pixel position so rgb lines up with de.
    always_comb begin
        bar_cnt_next = bar_cnt;
        bar_idx_next = bar_idx;
        if (line_load) begin
            bar_cnt_next = BAR_LAST;
            bar_idx_next = '0;
        end else if (bar_cnt == '0) begin
            bar_cnt_next = BAR_LAST;
            bar_idx_next = bar_idx + 3'd1;
        end else begin
            bar_cnt_next = bar_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bar_cnt <= BAR_LAST;
            bar_idx <= '0;
            rgb     <= '0;
        end else if (en) begin
            bar_cnt <= bar_cnt_next;
            bar_idx <= bar_idx_next;
            rgb     <= de_next ? bar_colour(bar_idx_next) : 16'h0000;
        end
    end

endmodule

// File: rtl/lcd_timing_gen.sv
// Pixel-clock video timing generator (hsync/vsync/de/x/y, line/frame pulses).
// Define LCD_TEST_PATTERN_EN to add the rgb colour-bar output.
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b0,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start
`ifdef LCD_TEST_PATTERN_EN
    ,
    output logic [15:0]      rgb
`endif
);

    localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic [CNT_W-1:0] h_next;
    logic [CNT_W-1:0] v_next;
    logic             h_wrap;
    logic             de_next;
    logic             hs_on;
    logic             vs_on;

    // Outputs are decoded from the next counter value so that, once
    // registered, they describe the counter held in the same cycle.
    always_comb begin
        h_wrap  = (h_cnt == H_LAST);
        h_next  = h_wrap ? '0 : h_cnt + 1'b1;
        v_next  = v_cnt;
        if (h_wrap) begin
            v_next = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end
        de_next = (h_next < H_ACT) && (v_next < V_ACT);
        hs_on   = (h_next >= HS_FIRST) && (h_next <= HS_LAST);
        vs_on   = (v_next >= VS_FIRST) && (v_next <= VS_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt       <= H_LAST;
            v_cnt       <= V_LAST;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (en) begin
            h_cnt       <= h_next;
            v_cnt       <= v_next;
            de          <= de_next;
            x           <= de_next ? h_next : '0;
            y           <= de_next ? v_next : '0;
            hsync       <= hs_on ? SYNC_POL : ~SYNC_POL;
            vsync       <= vs_on ? SYNC_POL : ~SYNC_POL;
            line_start  <= (h_next == '0);
            frame_start <= (h_next == '0) && (v_next == '0);
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

`ifdef LCD_TEST_PATTERN_EN
    lcd_colour_bars #(
        .CNT_W(CNT_W),
        .BAR_W(H_ACTIVE / 8)
    ) u_bars (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .line_load(h_next == '0),
        .de_next  (de_next),
        .rgb      (rgb)
    );
`endif

endmodule
